tpm_buf_arbiter: RTL and testbench

//  Arbitrates the shared 512x32 TPM command/response buffer RAM between the Wishbone CPU port and the LPC data-provider byte port.

---
 rtl/tpm_buf_arbiter_pkg.sv | 19 +
 rtl/tpm_buf_arbiter_sync_2ff.sv | 22 ++
 rtl/tpm_buf_arbiter.sv | 176 +++++++++++++++++
 tb/tb_tpm_buf_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpm_buf_arbiter_pkg.sv
// rtl/tpm_buf_arbiter_pkg.sv - shared types and constants for the TPM buffer arbiter
package tpm_buf_arbiter_pkg;

    localparam int TPM_RAM_ADDR_WIDTH = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RESP    = 3'd3,
        ST_DP_WAIT = 3'd4
    } state_t;

    // One-hot byte write enable for a little-endian byte lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/tpm_buf_arbiter_sync_2ff.sv
// rtl/tpm_buf_arbiter_sync_2ff.sv - generic 2-flop level synchronizer
module tpm_buf_arbiter_sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tpm_buf_arbiter.sv
// rtl/tpm_buf_arbiter.sv - arbitrates the shared TPM buffer RAM between WB CPU and LPC DP ports
module tpm_buf_arbiter
    import tpm_buf_arbiter_pkg::*;
#(
    parameter int         ADDR_W       = TPM_RAM_ADDR_WIDTH,
    parameter bit         LOCK_ON_EXEC = 1'b1,
    parameter logic [7:0] DP_RD_FILL   = 8'hFF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              exec_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    input  logic              dp_req_i,
    input  logic              dp_we_i,
    input  logic [ADDR_W-1:0] dp_adr_i,
    input  logic [7:0]        dp_dat_i,
    output logic [7:0]        dp_dat_o,
    output logic              dp_ack_o,
    output logic [ADDR_W-3:0] ram_a_o,
    output logic [31:0]       ram_wd_o,
    output logic [3:0]        ram_wen_o,
    input  logic [31:0]       ram_rd_i
);

    state_t            state_q, state_d;
    logic              cur_dp_q, cur_dp_d;
    logic [1:0]        lane_q, lane_d;
    logic              rr_last_dp_q, rr_last_dp_d;
    logic [31:0]       wb_dat_d;
    logic              wb_ack_d, wb_err_d;
    logic [7:0]        dp_dat_d;
    logic              dp_ack_d;
    logic [ADDR_W-3:0] ram_a_d;
    logic [31:0]       ram_wd_d;
    logic [3:0]        ram_wen_d;

    logic dp_req_s;
    logic wb_req;
    logic dp_new;
    logic pick_dp;
    logic permit;
    logic unused_bits;

    // WB byte offset is irrelevant: the CPU always addresses whole words.
    assign unused_bits = ^wb_adr_i[1:0];

    tpm_buf_arbiter_sync_2ff u_dp_req_sync (
        .clk  (clk_i),
        .rstn (rstn_i),
        .d    (dp_req_i),
        .q    (dp_req_s)
    );

    assign wb_req = wb_cyc_i & wb_stb_i;
    assign dp_new = dp_req_s & ~dp_ack_o;

    // Next-state and next-output logic; all outputs come straight from flops.
    always_comb begin
        state_d      = state_q;
        cur_dp_d     = cur_dp_q;
        lane_d       = lane_q;
        rr_last_dp_d = rr_last_dp_q;
        wb_dat_d     = wb_dat_o;
        wb_ack_d     = 1'b0;
        wb_err_d     = 1'b0;
        dp_dat_d     = dp_dat_o;
        dp_ack_d     = dp_ack_o;
        ram_a_d      = ram_a_o;
        ram_wd_d     = ram_wd_o;
        ram_wen_d    = 4'b0000;
        pick_dp      = 1'b0;
        permit       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wb_req || dp_new) begin
                    // On contention the side not served last wins.
                    pick_dp      = dp_new && (!wb_req || !rr_last_dp_q);
                    permit       = !LOCK_ON_EXEC || (pick_dp ? !exec_i : exec_i);
                    rr_last_dp_d = pick_dp;
                    cur_dp_d     = pick_dp;
                    if (pick_dp) begin
                        lane_d = dp_adr_i[1:0];
                    end
                    if (permit) begin
                        state_d = ST_ISSUE;
                        if (pick_dp) begin
                            ram_a_d   = dp_adr_i[ADDR_W-1:2];
                            ram_wd_d  = {4{dp_dat_i}};
                            ram_wen_d = dp_we_i ? lane_mask(dp_adr_i[1:0]) : 4'b0000;
                        end else begin
                            ram_a_d   = wb_adr_i[ADDR_W-1:2];
                            ram_wd_d  = wb_dat_i;
                            ram_wen_d = wb_we_i ? wb_sel_i : 4'b0000;
                        end
                    end else begin
                        // Refused: answer immediately without touching the RAM.
                        state_d = ST_RESP;
                        if (pick_dp) begin
                            dp_ack_d = 1'b1;
                            dp_dat_d = DP_RD_FILL;
                        end else begin
                            wb_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (cur_dp_q) begin
                    dp_ack_d = 1'b1;
                    dp_dat_d = ram_rd_i[{lane_q, 3'b000} +: 8];
                end else if (wb_req) begin
                    // A master that dropped its strobe gets no ack.
                    wb_ack_d = 1'b1;
                    wb_dat_d = ram_rd_i;
                end
            end
            ST_RESP: begin
                state_d = cur_dp_q ? ST_DP_WAIT : ST_IDLE;
            end
            ST_DP_WAIT: begin
                if (!dp_req_s) begin
                    dp_ack_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output register bank; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            cur_dp_q     <= 1'b0;
            lane_q       <= 2'b00;
            rr_last_dp_q <= 1'b1;
            wb_dat_o     <= '0;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            dp_dat_o     <= '0;
            dp_ack_o     <= 1'b0;
            ram_a_o      <= '0;
            ram_wd_o     <= '0;
            ram_wen_o    <= '0;
        end else begin
            state_q      <= state_d;
            cur_dp_q     <= cur_dp_d;
            lane_q       <= lane_d;
            rr_last_dp_q <= rr_last_dp_d;
            wb_dat_o     <= wb_dat_d;
            wb_ack_o     <= wb_ack_d;
            wb_err_o     <= wb_err_d;
            dp_dat_o     <= dp_dat_d;
            dp_ack_o     <= dp_ack_d;
            ram_a_o      <= ram_a_d;
            ram_wd_o     <= ram_wd_d;
            ram_wen_o    <= ram_wen_d;
        end
    end

endmodule

// File: tb/tb_tpm_buf_arbiter.sv
// tb/tb_tpm_buf_arbiter.sv - scoreboard testbench for tpm_buf_arbiter
module tb_tpm_buf_arbiter;

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        exec_r = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [10:0] wb_adr = '0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_dat = '0;
    logic        dp_req = 1'b0, dp_we = 1'b0;
    logic [10:0] dp_adr = '0;
    logic [7:0]  dp_dat = '0;
    logic        mem_clr = 1'b1;

    logic [31:0] wb_dat0, wb_dat1;
    logic        wb_ack0, wb_ack1, wb_err0, wb_err1;
    logic [7:0]  dp_dat0, dp_dat1;
    logic        dp_ack0, dp_ack1;
    logic [8:0]  ram_a0, ram_a1;
    logic [31:0] ram_wd0, ram_wd1, ram_rd0, ram_rd1;
    logic [3:0]  ram_wen0, ram_wen1;

    logic [31:0] mem0 [0:511];
    logic [31:0] mem1 [0:511];
    logic [31:0] ref_mem [0:511];

    exp_t exp_q[$];
    bit   side_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tpm_buf_arbiter #(.ADDR_W(11), .LOCK_ON_EXEC(1'b1), .DP_RD_FILL(8'hFF)) u0 (
        .clk_i(clk), .rstn_i(rstn), .exec_i(exec_r),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
        .wb_sel_i(wb_sel), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat0), .wb_ack_o(wb_ack0),
        .wb_err_o(wb_err0), .dp_req_i(dp_req), .dp_we_i(dp_we), .dp_adr_i(dp_adr),
        .dp_dat_i(dp_dat), .dp_dat_o(dp_dat0), .dp_ack_o(dp_ack0), .ram_a_o(ram_a0),
        .ram_wd_o(ram_wd0), .ram_wen_o(ram_wen0), .ram_rd_i(ram_rd0)
    );

    tpm_buf_arbiter #(.ADDR_W(11), .LOCK_ON_EXEC(1'b0), .DP_RD_FILL(8'hFF)) u1 (
        .clk_i(clk), .rstn_i(rstn), .exec_i(exec_r),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
        .wb_sel_i(wb_sel), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat1), .wb_ack_o(wb_ack1),
        .wb_err_o(wb_err1), .dp_req_i(dp_req), .dp_we_i(dp_we), .dp_adr_i(dp_adr),
        .dp_dat_i(dp_dat), .dp_dat_o(dp_dat1), .dp_ack_o(dp_ack1), .ram_a_o(ram_a1),
        .ram_wd_o(ram_wd1), .ram_wen_o(ram_wen1), .ram_rd_i(ram_rd1)
    );

    // Synchronous RAMs with 1-cycle read latency, one per DUT
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wen0[b]) mem0[ram_a0][8*b +: 8] <= ram_wd0[8*b +: 8];
                if (ram_wen1[b]) mem1[ram_a1][8*b +: 8] <= ram_wd1[8*b +: 8];
            end
        end
        ram_rd0 <= mem0[ram_a0];
        ram_rd1 <= mem1[ram_a1];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({wb_ack0, wb_err0, dp_ack0, ram_wen0} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, want 0", {wb_ack0, wb_err0, dp_ack0, ram_wen0});
        end
        checks++;
        if ({wb_dat0, dp_dat0, ram_a0, ram_wd0} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h, want 0", {wb_dat0, dp_dat0, ram_a0, ram_wd0});
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({wb_ack0, wb_err0, dp_ack0, ram_wen0} !== 7'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b, want 0", {wb_ack0, wb_err0, dp_ack0, ram_wen0});
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [10:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input bit exp_err, input bit drop_exec,
                           input string name);
        exp_t e;
        exp_t got_e;
        logic [8:0] a_before;
        int n;
        bit got;
        a_before   = ram_a0;
        e.is_err   = exp_err;
        e.chk_data = !we && !exp_err;
        e.data     = ref_mem[adr[10:2]];
        if (we && !exp_err)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr[10:2]][8*b +: 8] = dat[8*b +: 8];
        exp_q.push_back(e);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat = dat;
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1 && !exp_err) begin
                checks++;
                if (ram_a0 !== adr[10:2] || ram_wen0 !== (we ? sel : 4'b0000) ||
                    (we && ram_wd0 !== dat)) begin
                    errors++;
                    $display("FAIL %s_issue: a=%h wen=%b wd=%h, want a=%h wen=%b wd=%h",
                             name, ram_a0, ram_wen0, ram_wd0, adr[10:2], we ? sel : 4'b0000, dat);
                end
            end
            if (n == 1 && exp_err) begin
                checks++;
                if (ram_wen0 !== 4'b0000 || ram_a0 !== a_before) begin
                    errors++;
                    $display("FAIL %s_no_ram: a=%h wen=%b, want a=%h wen=0", name, ram_a0, ram_wen0, a_before);
                end
            end
            if (n == 2 && drop_exec) exec_r = 1'b0;
            if (wb_ack0 || wb_err0) got = 1;
        end
        got_e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: no ack/err within 20 cycles", name);
        end else begin
            if ({wb_err0, wb_ack0} !== {got_e.is_err, !got_e.is_err}) begin
                errors++;
                $display("FAIL %s_kind: err/ack=%b%b, want %b%b", name, wb_err0, wb_ack0,
                         got_e.is_err, !got_e.is_err);
            end
            checks++;
            if (n != (exp_err ? 1 : 3)) begin
                errors++;
                $display("FAIL %s_latency: %0d cycles, want %0d", name, n, exp_err ? 1 : 3);
            end
            if (got_e.chk_data) begin
                checks++;
                if (wb_dat0 !== got_e.data) begin
                    errors++;
                    $display("FAIL %s_data: got %h, want %h", name, wb_dat0, got_e.data);
                end
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_ack0 !== 1'b0 || wb_err0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: ack=%b err=%b one cycle later, want 0 0", name, wb_ack0, wb_err0);
        end
    endtask

    task automatic dp_xfer(input logic we, input logic [10:0] adr, input logic [7:0] dat,
                           input bit refused, input string name);
        exp_t e;
        exp_t got_e;
        logic [31:0] w;
        int n;
        int m;
        bit got;
        w          = ref_mem[adr[10:2]];
        e.is_err   = 1'b0;
        e.chk_data = !we;
        e.data     = refused ? 32'h0000_00FF : {24'b0, w[8*adr[1:0] +: 8]};
        if (we && !refused) ref_mem[adr[10:2]][8*adr[1:0] +: 8] = dat;
        exp_q.push_back(e);
        @(negedge clk);
        dp_we = we; dp_adr = adr; dp_dat = dat; dp_req = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (n == 3 && we && !refused) begin
                checks++;
                if (ram_a0 !== adr[10:2] || ram_wen0 !== (4'b0001 << adr[1:0]) || ram_wd0 !== {4{dat}}) begin
                    errors++;
                    $display("FAIL %s_issue: a=%h wen=%b wd=%h, want a=%h wen=%b wd=%h", name, ram_a0,
                             ram_wen0, ram_wd0, adr[10:2], 4'b0001 << adr[1:0], {4{dat}});
                end
            end
            if (dp_ack0) got = 1;
        end
        got_e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: no dp ack within 30 cycles", name);
        end else begin
            if (n != (refused ? 3 : 5)) begin
                errors++;
                $display("FAIL %s_latency: %0d cycles, want %0d", name, n, refused ? 3 : 5);
            end
            if (got_e.chk_data) begin
                checks++;
                if (dp_dat0 !== got_e.data[7:0]) begin
                    errors++;
                    $display("FAIL %s_data: got %h, want %h", name, dp_dat0, got_e.data[7:0]);
                end
            end
        end
        dp_req = 1'b0;
        m = 0;
        while (dp_ack0 && m < 10) begin
            @(negedge clk);
            m++;
        end
        checks++;
        if (m < 2 || m > 3) begin
            errors++;
            $display("FAIL %s_ack_release: ack dropped after %0d cycles, want 2..3", name, m);
        end
    endtask

    task automatic test_wb_write;
        exec_r = 1'b1;
        wb_xfer(1'b1, 11'h010, 4'b0110, 32'hA1B2C3D4, 1'b0, 1'b0, "wb_wr");
        wb_xfer(1'b0, 11'h010, 4'b0000, 32'h0, 1'b0, 1'b0, "wb_rd");
    endtask

    task automatic test_dp;
        exec_r = 1'b0;
        dp_xfer(1'b1, 11'h013, 8'h5A, 1'b0, "dp_wr");
        dp_xfer(1'b0, 11'h013, 8'h00, 1'b0, "dp_rd3");
        dp_xfer(1'b0, 11'h011, 8'h00, 1'b0, "dp_rd1");
    endtask

    task automatic test_lock;
        exec_r = 1'b0;
        wb_xfer(1'b0, 11'h010, 4'b0000, 32'h0, 1'b1, 1'b0, "wb_refused");
        exec_r = 1'b1;
        dp_xfer(1'b0, 11'h013, 8'h00, 1'b1, "dp_refused");
    endtask

    task automatic test_exec_toggle;
        exec_r = 1'b1;
        wb_xfer(1'b1, 11'h020, 4'b1111, 32'h11223344, 1'b0, 1'b1, "wb_toggle");
        wb_xfer(1'b0, 11'h020, 4'b0000, 32'h0, 1'b1, 1'b0, "wb_after_toggle");
        exec_r = 1'b1;
        wb_xfer(1'b0, 11'h020, 4'b0000, 32'h0, 1'b0, 1'b0, "wb_toggle_rd");
    endtask

    task automatic test_reset_mid;
        int stale;
        exec_r = 1'b1;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 11'h024; wb_sel = 4'hF;
        repeat (2) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({wb_ack0, wb_err0, dp_ack0, ram_wen0, ram_a0, ram_wd0, wb_dat0, dp_dat0} !== '0) begin
            errors++;
            $display("FAIL reset_mid: outputs %h, want all 0",
                     {wb_ack0, wb_err0, dp_ack0, ram_wen0, ram_a0, ram_wd0, wb_dat0, dp_dat0});
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_ack0 || wb_err0 || dp_ack0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL reset_stale_ack: %0d cycles with ack/err, want 0", stale);
        end
        exec_r = 1'b0;
        dp_xfer(1'b0, 11'h013, 8'h00, 1'b0, "dp_after_reset");
    endtask

    task automatic test_round_robin;
        int cyc;
        int ev;
        bit s;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exec_r = 1'b1;
        for (int i = 0; i < 6; i++) side_q.push_back(i[0]);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 11'h010;
        dp_we = 1'b0; dp_adr = 11'h013; dp_req = 1'b1;
        cyc = 0;
        ev = 0;
        while (ev < 6 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (wb_ack1) begin
                s = side_q.pop_front();
                ev++;
                checks++;
                if (s !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_order_%0d: WB granted, want DP", ev);
                end
            end
            if (dp_ack1 && dp_req) begin
                s = side_q.pop_front();
                ev++;
                checks++;
                if (s !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_order_%0d: DP granted, want WB", ev);
                end
                dp_req = 1'b0;
            end else if (!dp_ack1 && !dp_req) begin
                dp_req = 1'b1;
            end
        end
        checks++;
        if (ev != 6) begin
            errors++;
            $display("FAIL rr_timeout: %0d grants seen, want 6", ev);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; dp_req = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        test_reset();
        test_wb_write();
        test_dp();
        test_lock();
        test_exec_toggle();
        test_reset_mid();
        test_round_robin();
        checks++;
        if (exp_q.size() != 0 || side_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, want 0", exp_q.size(), side_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
